// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run sequencer: lifecycle states and the
// rule that places the halt mailbox in data memory.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } run_state_e;

  // The halt mailbox sits in the last data-memory word so program data can
  // grow upward from word 0 without colliding with it.
  function automatic int mailbox_word(input int size);
    return size - 1;
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Bundle of every signal between the run sequencer, the PS/AXI glue and the
// processor top. The sequencer is the slave of the glue's commands and the
// master of the processor's load/mailbox ports; the master modport is the
// view seen by whoever drives start/abort and models the processor.
interface core_run_ctrl_if #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 64,
  parameter int NUM_COL = 4,
  parameter int CNT_W   = 32
);
  localparam int IDX_W = $clog2(SIZE);
  localparam int LEN_W = IDX_W + 1;

  // Command / status towards the PS glue
  logic               start;
  logic               abort;
  logic [LEN_W-1:0]   prog_len;
  logic [CNT_W-1:0]   max_cycles;
  logic               busy;
  logic               done;
  logic               timed_out;
  logic [WIDTH-1:0]   halt_code;
  logic [CNT_W-1:0]   cycle_count;

  // Program word stream
  logic [WIDTH-1:0]   ld_data;
  logic               ld_valid;
  logic               ld_ready;

  // Processor instruction-memory write port and reset
  logic [WIDTH-1:0]   instr_in;
  logic [IDX_W+1:0]   instr_wr_addr;
  logic               instr_wr_en;
  logic               core_rst;

  // Processor data-memory B port
  logic [WIDTH-1:0]   dmem_data_in;
  logic [IDX_W-1:0]   dmem_word_addr;
  logic [NUM_COL-1:0] dmem_byte_wr_en;
  logic [WIDTH-1:0]   dmem_data_out;

  modport slave (
    input  start, abort, prog_len, max_cycles, ld_data, ld_valid, dmem_data_out,
    output busy, done, timed_out, halt_code, cycle_count, ld_ready,
           instr_in, instr_wr_addr, instr_wr_en, core_rst,
           dmem_data_in, dmem_word_addr, dmem_byte_wr_en
  );

  modport master (
    output start, abort, prog_len, max_cycles, ld_data, ld_valid, dmem_data_out,
    input  busy, done, timed_out, halt_code, cycle_count, ld_ready,
           instr_in, instr_wr_addr, instr_wr_en, core_rst,
           dmem_data_in, dmem_word_addr, dmem_byte_wr_en
  );

endinterface

// File: rtl/run_budget_counter.sv
// Saturating count of cycles spent in RUN plus the budget compare. expire_o
// is raised during the last permitted RUN cycle so the sequencer can leave
// RUN on that edge and the final count equals the budget.
module run_budget_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] max_cycles_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear on a new sequence, otherwise step while running, sticking at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero budget means run without limit.
  assign expire_o = (max_cycles_i != '0) && (count_q == (max_cycles_i - CNT_W'(1)));
  assign count_o  = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Boot/run sequencer for the pipelined processor: streams a program into
// instruction memory with the core held in reset, clears the halt mailbox,
// releases the core and polls the mailbox until software posts a nonzero
// halt code or the cycle budget runs out.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SIZE           = 64,
  parameter int NUM_COL        = 4,
  parameter int HALT_WORD_ADDR = mailbox_word(SIZE),
  parameter int CNT_W          = 32
) (
  input logic             clk,
  input logic             reset,
  core_run_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int LEN_W = IDX_W + 1;

  run_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rd_vld_q, rd_vld_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic [WIDTH-1:0] halt_code_q, halt_code_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             expire;
  logic [CNT_W-1:0] cycle_count;
  logic             ld_xfer;
  logic             halt_seen;
  logic             last_word;
  logic [LEN_W-1:0] len_clamped;

  // Programs longer than the instruction memory are truncated to its size.
  assign len_clamped = (bus.prog_len > LEN_W'(SIZE)) ? LEN_W'(SIZE) : bus.prog_len;

  assign ld_xfer   = (state_q == LOAD) && bus.ld_valid;
  assign last_word = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  // The mailbox read issued during CLEAR returns on the first RUN cycle and
  // predates the clear, so it is masked by rd_vld_q.
  assign halt_seen = (state_q == RUN) && rd_vld_q && (bus.dmem_data_out != '0);
  assign cnt_en    = (state_q == RUN);

  run_budget_counter #(
    .CNT_W(CNT_W)
  ) u_budget (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .max_cycles_i(bus.max_cycles),
    .count_o     (cycle_count),
    .expire_o    (expire)
  );

  // Next-state and status updates; abort overrides everything, halt beats budget expiry.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    halt_code_d = halt_code_q;
    rd_vld_d    = (state_q == RUN);
    cnt_clr     = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            len_d       = len_clamped;
            idx_d       = '0;
            done_d      = 1'b0;
            timed_out_d = 1'b0;
            halt_code_d = '0;
            cnt_clr     = 1'b1;
            state_d     = (len_clamped == '0) ? CLEAR : LOAD;
          end
        end
        LOAD: begin
          if (ld_xfer) begin
            idx_d = idx_q + IDX_W'(1);
            if (last_word) begin
              state_d = CLEAR;
            end
          end
        end
        CLEAR: begin
          state_d = RUN;
        end
        RUN: begin
          if (halt_seen) begin
            halt_code_d = bus.dmem_data_out;
            timed_out_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else if (expire) begin
            timed_out_d = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer state and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      rd_vld_q    <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      halt_code_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_vld_q    <= rd_vld_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      halt_code_q <= halt_code_d;
    end
  end

  // Load port: writes happen in the same cycle as the stream handshake.
  assign bus.ld_ready      = (state_q == LOAD);
  assign bus.instr_wr_en   = ld_xfer;
  assign bus.instr_in      = ld_xfer ? bus.ld_data : '0;
  assign bus.instr_wr_addr = {idx_q, 2'b00};

  // The core only runs in RUN; decoding from the state register means an
  // asynchronous reset puts the core back into reset immediately.
  assign bus.core_rst = (state_q != RUN);

  // Mailbox port: always addresses the mailbox, writes zero only in CLEAR.
  assign bus.dmem_word_addr  = IDX_W'(HALT_WORD_ADDR);
  assign bus.dmem_data_in    = '0;
  assign bus.dmem_byte_wr_en = (state_q == CLEAR) ? {NUM_COL{1'b1}} : {NUM_COL{1'b0}};

  assign bus.busy        = (state_q == LOAD) || (state_q == CLEAR) || (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.halt_code   = halt_code_q;
  assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed and randomized checks of the boot/run sequencer against a
// run-outcome model computed from the mailbox response schedule.
module tb_core_run_ctrl;

  localparam int WIDTH  = 32;
  localparam int SIZE   = 64;
  localparam int NCOL   = 4;
  localparam int CNT_W  = 32;
  localparam int RESP_N = 48;

  logic clk = 1'b0;
  logic reset;

  core_run_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NCOL), .CNT_W(CNT_W)) ifc ();

  core_run_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NCOL), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Mailbox value returned on RUN cycle k (k = 0 is the first RUN cycle).
  logic [31:0] resp [RESP_N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_resp();
    for (int i = 0; i < RESP_N; i++) resp[i] = 32'h0;
  endtask

  function automatic logic [31:0] resp_at(input int k);
    return (k >= 0 && k < RESP_N) ? resp[k] : 32'h0;
  endfunction

  // Full sequence from IDLE/DONE. vmode: 0 valid always, 1 random, 2 pattern 1,0,0,1.
  // abort_at >= 0 pulses abort on that RUN cycle; poke_start pulses start on RUN cycle 1.
  task automatic run_seq(input int plen, input int vmode, input int maxc,
                         input int abort_at, input bit poke_start);
    int len, nw, slot, hk, tk, e;
    bit halt, v;
    logic [31:0] d;
    // Outcome prediction: first nonzero mailbox value after the stale first
    // cycle halts; otherwise the budget ends the run on its last cycle.
    len = (plen > SIZE) ? SIZE : plen;
    hk = -1;
    for (int i = 1; i < RESP_N; i++) if (hk < 0 && resp[i] != 0) hk = i;
    tk = (maxc != 0) ? maxc - 1 : -1;
    if (hk >= 0 && (tk < 0 || hk <= tk)) begin e = hk; halt = 1'b1; end
    else begin e = tk; halt = 1'b0; end
    if (e < 0) begin
      n_err++;
      $display("FAIL run_setup no terminating condition");
      $fatal(1, "unbounded run requested");
    end

    ifc.max_cycles = CNT_W'(maxc);
    ifc.prog_len   = 7'(plen);
    ifc.start      = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("start_busy", ifc.busy, 1);
    chk("start_done_clr", ifc.done, 0);
    chk("start_to_clr", ifc.timed_out, 0);
    chk("start_halt_clr", ifc.halt_code, 0);
    chk("start_cnt_clr", ifc.cycle_count, 0);

    nw = 0; slot = 0;
    while (nw < len) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = ((slot % 4) == 0) || ((slot % 4) == 3);
      endcase
      d = $urandom;
      ifc.ld_valid = v;
      ifc.ld_data  = d;
      #1;
      chk("load_ready", ifc.ld_ready, 1);
      chk("load_core_rst", ifc.core_rst, 1);
      chk("load_wr_en", ifc.instr_wr_en, v);
      if (v) begin
        chk("load_addr", ifc.instr_wr_addr, nw * 4);
        chk("load_data", ifc.instr_in, d);
      end
      @(posedge clk); #1;
      ifc.ld_valid = 1'b0;
      if (v) nw++;
      slot++;
      if (slot > 4000) begin
        n_err++;
        $display("FAIL load_bound words=%0d expected=%0d", nw, len);
        $fatal(1, "load did not complete");
      end
    end

    chk("clear_bwe", ifc.dmem_byte_wr_en, 4'hF);
    chk("clear_addr", ifc.dmem_word_addr, SIZE - 1);
    chk("clear_data", ifc.dmem_data_in, 0);
    chk("clear_core_rst", ifc.core_rst, 1);
    chk("clear_ready", ifc.ld_ready, 0);
    chk("clear_wr_en", ifc.instr_wr_en, 0);
    @(posedge clk); #1;

    for (int k = 0; k <= e; k++) begin
      ifc.dmem_data_out = resp_at(k);
      if (poke_start && k == 1) ifc.start = 1'b1;
      if (k == abort_at) ifc.abort = 1'b1;
      #1;
      chk("run_core_rst", ifc.core_rst, 0);
      chk("run_bwe", ifc.dmem_byte_wr_en, 0);
      chk("run_addr", ifc.dmem_word_addr, SIZE - 1);
      chk("run_cnt", ifc.cycle_count, k);
      chk("run_done", ifc.done, 0);
      @(posedge clk); #1;
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      if (k == abort_at) begin
        ifc.dmem_data_out = 32'h0;
        chk("abort_core_rst", ifc.core_rst, 1);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_done", ifc.done, 0);
        chk("abort_to", ifc.timed_out, 0);
        return;
      end
    end
    ifc.dmem_data_out = 32'h0;
    chk("end_done", ifc.done, 1);
    chk("end_core_rst", ifc.core_rst, 1);
    chk("end_busy", ifc.busy, 0);
    chk("end_to", ifc.timed_out, !halt);
    chk("end_halt_code", ifc.halt_code, halt ? resp_at(e) : 32'h0);
    chk("end_cnt", ifc.cycle_count, e + 1);
    @(posedge clk); #1;
    chk("hold_done", ifc.done, 1);
    chk("hold_cnt", ifc.cycle_count, e + 1);
  endtask

  initial begin
    int plen, maxc;
    reset = 1'b0;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.prog_len = '0; ifc.max_cycles = '0;
    ifc.ld_data = '0; ifc.ld_valid = 1'b0; ifc.dmem_data_out = '0;
    clear_resp();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_rst", ifc.core_rst, 1);
    chk("rst_ready", ifc.ld_ready, 0);
    chk("rst_wr_en", ifc.instr_wr_en, 0);
    chk("rst_wr_addr", ifc.instr_wr_addr, 0);
    chk("rst_bwe", ifc.dmem_byte_wr_en, 0);
    chk("rst_addr", ifc.dmem_word_addr, SIZE - 1);
    chk("rst_din", ifc.dmem_data_in, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_to", ifc.timed_out, 0);
    chk("rst_halt", ifc.halt_code, 0);
    chk("rst_cnt", ifc.cycle_count, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", ifc.busy, 0);

    // Four-word load, halt code 1 after ten zero polls
    clear_resp();
    resp[10] = 32'h1;
    run_seq(4, 0, 0, -1, 1'b0);

    // Budget of five with a silent mailbox
    clear_resp();
    run_seq(3, 0, 5, -1, 1'b0);

    // Stale first-cycle read must not halt
    clear_resp();
    resp[0] = 32'hDEAD;
    resp[6] = 32'h55;
    run_seq(2, 0, 0, -1, 1'b0);

    // Gapped stream 1,0,0,1
    clear_resp();
    resp[3] = 32'hCAFE_0001;
    run_seq(4, 2, 0, -1, 1'b0);

    // Halt on the budget's last cycle: halt wins
    clear_resp();
    resp[3] = 32'hABC;
    run_seq(1, 0, 4, -1, 1'b0);

    // Empty program skips LOAD; start during RUN is ignored
    clear_resp();
    resp[5] = 32'h7;
    run_seq(0, 0, 0, -1, 1'b1);

    // Oversized program clamped to memory size
    clear_resp();
    resp[2] = 32'h99;
    run_seq(100, 1, 0, -1, 1'b0);

    // Abort mid-RUN
    clear_resp();
    resp[8] = 32'h5;
    run_seq(2, 0, 0, 3, 1'b1);

    // Timeout run, then abort from DONE keeps the flags
    clear_resp();
    run_seq(1, 0, 2, -1, 1'b0);
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0;
    chk("dabort_busy", ifc.busy, 0);
    chk("dabort_done", ifc.done, 1);
    chk("dabort_to", ifc.timed_out, 1);
    chk("dabort_core_rst", ifc.core_rst, 1);

    // start and abort together: abort wins, nothing cleared
    ifc.prog_len = 7'd3;
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    chk("sa_busy", ifc.busy, 0);
    chk("sa_done", ifc.done, 1);
    chk("sa_cnt", ifc.cycle_count, 2);

    // Asynchronous reset in the middle of RUN
    clear_resp();
    ifc.max_cycles = '0;
    ifc.prog_len = 7'd0;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    @(posedge clk); #1;
    chk("areset_run", ifc.core_rst, 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_core_rst", ifc.core_rst, 1);
    chk("areset_busy", ifc.busy, 0);
    chk("areset_cnt", ifc.cycle_count, 0);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("areset_idle", ifc.busy, 0);

    // Randomized sequences
    for (int r = 0; r < 8; r++) begin
      clear_resp();
      plen = $urandom_range(0, 100);
      maxc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
      for (int i = 0; i < 40; i++) if ($urandom_range(0, 9) == 0) resp[i] = $urandom | 32'h1;
      if (maxc == 0) resp[39] = 32'h39;
      run_seq(plen, 1, maxc, -1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Sequencer that owns a pipelined_processor's boot and run lifecycle. It streams a program into instruction memory through the instr write port and holds the core in reset while loading. It then clears a mailbox word in data memory, releases the core, and polls the mailbox through the data-memory B port. It stops the core when software writes a nonzero halt code or a cycle budget expires. It sits between the PS/AXI glue and the processor top.

Parameters:
WIDTH, 32, bits per word
SIZE, 64, words in each of instruction and data memory
NUM_COL, 4, byte-write columns on dmem B port
HALT_WORD_ADDR, SIZE-1, dmem word index of halt mailbox
CNT_W, 32, width of cycle counter/budget

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin load/run sequence
abort  in  1  single-cycle pulse: stop sequence, return to IDLE
prog_len  in  $clog2(SIZE)+1  words to load (0 = skip load)
max_cycles  in  CNT_W  run budget in cycles (0 = unlimited)
ld_data  in  WIDTH  program word stream
ld_valid  in  1  stream valid
ld_ready  out  1  stream ready
instr_in  out  WIDTH  to processor instr_in
instr_wr_addr  out  $clog2(SIZE)+2  byte address to processor
instr_wr_en  out  1  instruction write strobe
core_rst  out  1  active-high reset driven to processor
dmem_data_in  out  WIDTH  to processor AXI_dmem_data_in
dmem_word_addr  out  $clog2(SIZE)  to AXI_dmem_word_addr
dmem_byte_wr_en  out  NUM_COL  to AXI_dmem_byte_wr_en
dmem_data_out  in  WIDTH  from AXI_dmem_data_out (1-cycle read latency)
busy  out  1  state is LOAD, CLEAR or RUN
done  out  1  sequence finished (sticky until next start)
timed_out  out  1  finish caused by budget expiry
halt_code  out  WIDTH  mailbox value captured at halt
cycle_count  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset (async, reset=0): state IDLE; core_rst=1; ld_ready=0; instr_wr_en=0; dmem_byte_wr_en=0; dmem_word_addr=HALT_WORD_ADDR; dmem_data_in=0; busy=0; done=0; timed_out=0; halt_code=0; cycle_count=0; word index=0.
- States: IDLE, LOAD, CLEAR, RUN, DONE. core_rst=1 in every state except RUN.
- IDLE/DONE + start:
  - latch len = min(prog_len, SIZE); clear done, timed_out, halt_code, cycle_count.
  - len=0 -> go to CLEAR; else go to LOAD.
- start is ignored in LOAD, CLEAR and RUN.
- LOAD:
  - ld_ready=1; a transfer occurs on ld_valid&ld_ready.
  - On a transfer, in the same cycle (combinational): instr_wr_en=1, instr_in=ld_data, instr_wr_addr={idx,2'b00}; idx increments.
  - The transfer with idx=len-1 goes to CLEAR.
  - ld_valid low stalls LOAD indefinitely (no timeout).
- CLEAR: exactly 1 cycle; dmem_word_addr=HALT_WORD_ADDR, dmem_data_in=0, dmem_byte_wr_en='1; next state RUN.
- RUN:
  - core_rst=0; dmem_byte_wr_en=0; dmem_word_addr=HALT_WORD_ADDR; cycle_count increments each RUN cycle.
  - A read-valid flag is cleared on RUN entry and set after the first RUN cycle. dmem_data_out is ignored while the flag is 0, so the read issued during CLEAR is never used.
  - Flag=1 and dmem_data_out!=0 -> halt_code<=dmem_data_out; go to DONE.
  - max_cycles!=0 and cycle_count==max_cycles-1 in the same cycle -> timed_out<=1; go to DONE.
  - If halt and timeout coincide, halt wins: capture halt_code, timed_out=0.
- DONE: done=1, core_rst=1, outputs held; start restarts the sequence.
- abort in any state -> IDLE next cycle. core_rst=1 from that edge. done/timed_out stay unchanged. Any partially loaded instruction memory is left as written.
- abort and start in the same cycle: abort wins.
- cycle_count saturates at all-ones; it does not wrap.
- Async reset mid-RUN asserts core_rst=1 immediately (combinational from state register reset).

Decomposition:
- Shared package core_ctrl_pkg holds the state enum typedef (IDLE, LOAD, CLEAR, RUN, DONE) and the mailbox address constant convention.
- One natural sub-module: run_budget_counter. It holds the saturating cycle counter and the compare against max_cycles, and outputs expire.

Test Plan:
- Reset, then start with prog_len=4 and ld_valid held high with words A0..A3 -> instr_wr_en for 4 cycles at addrs 0,4,8,12. Then 1 CLEAR cycle writes 0 to word 63 with byte_wr_en=4'hF. core_rst drops on the next cycle.
- In RUN, model dmem returns 0 for 10 cycles, then 32'h1 -> done=1, halt_code=1, timed_out=0, core_rst=1 the cycle after detection.
- max_cycles=5 with dmem always 0 -> DONE after 5 RUN cycles; cycle_count=5, timed_out=1.
- Stale-read guard: dmem_data_out=32'hDEAD on the first RUN cycle, then 0 -> no halt on that first cycle.
- ld_valid toggling 1,0,0,1 during LOAD -> writes only on valid cycles; addresses stay contiguous.
- abort during RUN -> IDLE next cycle, core_rst=1. start with prog_len=0 -> LOAD is skipped, CLEAR is entered directly. prog_len=100 -> clamped to 64 words.
